// File: rtl/orbit_pair.sv
// orbit_pair: two-ball orbit engine; one reversible Minsky rotation state drives both balls 180 deg apart.
// Optional Angle output and step counter are enabled by defining ORBIT_ANGLE_OUT_EN.
module orbit_pair #(
  parameter int         X_CENTER      = 320,
  parameter int         Y_CENTER      = 360,
  parameter int         RADIUS        = 80,
  parameter int         FRAC          = 8,
  parameter int         SHIFT         = 5,
  parameter int         FRAME_DIV     = 1,
  parameter logic [7:0] KEY_CW        = 8'h07,
  parameter logic [7:0] KEY_CCW       = 8'h04,
  parameter logic [7:0] KEY_RESTART   = 8'h2C,
  parameter int         BALL_SIZE     = 4,
  parameter int         STEPS_PER_REV = 201
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       Dead,
  output logic [9:0] BlueX,
  output logic [9:0] BlueY,
  output logic [9:0] RedX,
  output logic [9:0] RedY,
  output logic [9:0] BallS,
  output logic       Alive
`ifdef ORBIT_ANGLE_OUT_EN
  ,
  output logic [8:0] Angle
`endif
);

  localparam int W = 11 + FRAC;
  localparam logic signed [W-1:0] OX_START = W'(RADIUS << FRAC);
  localparam logic [7:0] CNT_LAST = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DEAD    = 2'd1,
    ST_RESPAWN = 2'd2
  } state_t;

  state_t                r_state;
  logic signed [W-1:0]   r_ox;
  logic signed [W-1:0]   r_oy;
  logic [7:0]            r_cnt;
  logic                  r_last_cw;

  logic signed [W-1:0]   w_cw_nx;
  logic signed [W-1:0]   w_cw_ny;
  logic signed [W-1:0]   w_ccw_nx;
  logic signed [W-1:0]   w_ccw_ny;
  logic                  w_is_cw;
  logic                  w_is_ccw;
  logic                  w_dir_key;
  logic [7:0]            w_cnt_eff;
  logic                  w_step;
  logic [7:0]            w_cnt_next;
  logic [9:0]            w_px;
  logic [9:0]            w_py;

  // Each direction updates one coordinate using the other's fresh value, which makes CW/CCW exact inverses.
  assign w_cw_nx  = r_ox - (r_oy >>> SHIFT);
  assign w_cw_ny  = r_oy + (w_cw_nx >>> SHIFT);
  assign w_ccw_ny = r_oy - (r_ox >>> SHIFT);
  assign w_ccw_nx = r_ox + (w_ccw_ny >>> SHIFT);

  assign w_is_cw   = (keycode == KEY_CW);
  assign w_is_ccw  = (keycode == KEY_CCW);
  assign w_dir_key = w_is_cw | w_is_ccw;

  // A direction reversal behaves like a fresh press: the divider restarts from zero.
  assign w_cnt_eff  = (w_is_cw == r_last_cw) ? r_cnt : 8'd0;
  assign w_step     = (w_cnt_eff == 8'd0);
  assign w_cnt_next = (w_cnt_eff == CNT_LAST) ? 8'd0 : (w_cnt_eff + 8'd1);

`ifdef ORBIT_ANGLE_OUT_EN
  localparam logic [8:0] ANG_LAST = 9'(STEPS_PER_REV - 1);
  logic [8:0] r_angle;
  logic [8:0] w_angle_inc;
  logic [8:0] w_angle_dec;

  assign w_angle_inc = (r_angle == ANG_LAST) ? 9'd0 : (r_angle + 9'd1);
  assign w_angle_dec = (r_angle == 9'd0) ? ANG_LAST : (r_angle - 9'd1);
  assign Angle       = r_angle;

  // Net CW step counter, wrapping modulo STEPS_PER_REV, cleared on reset and restart.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_angle <= 9'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!Dead && w_dir_key && w_step) begin
            r_angle <= w_is_cw ? w_angle_inc : w_angle_dec;
          end else begin
            r_angle <= r_angle;
          end
        end
        ST_DEAD: begin
          if (keycode == KEY_RESTART) begin
            r_angle <= 9'd0;
          end else begin
            r_angle <= r_angle;
          end
        end
        default: r_angle <= r_angle;
      endcase
    end
  end
`endif

  // Game FSM with rotation state and frame divider.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_RUN;
      r_ox      <= OX_START;
      r_oy      <= '0;
      r_cnt     <= 8'd0;
      r_last_cw <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (Dead) begin
            r_state <= ST_DEAD;
          end else if (w_dir_key) begin
            r_cnt     <= w_cnt_next;
            r_last_cw <= w_is_cw;
            if (w_step) begin
              if (w_is_cw) begin
                r_ox <= w_cw_nx;
                r_oy <= w_cw_ny;
              end else begin
                r_ox <= w_ccw_nx;
                r_oy <= w_ccw_ny;
              end
            end else begin
              r_ox <= r_ox;
            end
          end else begin
            r_cnt <= 8'd0;
          end
        end
        ST_DEAD: begin
          if (keycode == KEY_RESTART) begin
            r_ox    <= OX_START;
            r_oy    <= '0;
            r_cnt   <= 8'd0;
            r_state <= ST_RESPAWN;
          end else begin
            r_state <= ST_DEAD;
          end
        end
        ST_RESPAWN: begin
          if (keycode == 8'd0) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_RESPAWN;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Slicing above the fraction equals the floor shift; only the low 10 bits reach the screen.
  assign w_px  = r_ox[FRAC +: 10];
  assign w_py  = r_oy[FRAC +: 10];
  assign RedX  = 10'(X_CENTER) + w_px;
  assign RedY  = 10'(Y_CENTER) + w_py;
  assign BlueX = 10'(X_CENTER) - w_px;
  assign BlueY = 10'(Y_CENTER) - w_py;
  assign BallS = 10'(BALL_SIZE);
  assign Alive = (r_state == ST_RUN);

endmodule

// File: tb/tb_orbit_pair.sv
// tb_orbit_pair: directed and randomized checks of orbit_pair (FRAME_DIV=1 and FRAME_DIV=3 instances)
// against a behavioural model of the orbit game rules.
module tb_orbit_pair;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key;
  logic       dead;

  logic [9:0] a_bx, a_by, a_rx, a_ry, a_bs;
  logic [9:0] b_bx, b_by, b_rx, b_ry, b_bs;
  logic       a_alive, b_alive;
`ifdef ORBIT_ANGLE_OUT_EN
  logic [8:0] a_ang, b_ang;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  orbit_pair #(.FRAME_DIV(1)) u_a (
    .frame_clk(clk), .Reset(rst), .keycode(key), .Dead(dead),
    .BlueX(a_bx), .BlueY(a_by), .RedX(a_rx), .RedY(a_ry), .BallS(a_bs), .Alive(a_alive)
`ifdef ORBIT_ANGLE_OUT_EN
    , .Angle(a_ang)
`endif
  );

  orbit_pair #(.FRAME_DIV(3)) u_b (
    .frame_clk(clk), .Reset(rst), .keycode(key), .Dead(dead),
    .BlueX(b_bx), .BlueY(b_by), .RedX(b_rx), .RedY(b_ry), .BallS(b_bs), .Alive(b_alive)
`ifdef ORBIT_ANGLE_OUT_EN
    , .Angle(b_ang)
`endif
  );

  // Reference model: 0 = running, 1 = dead, 2 = respawning
  longint m_ox[2];
  longint m_oy[2];
  int     m_st[2];
  int     m_hold[2];
  int     m_dir[2];
  int     m_ang[2];
  int     fdiv[2] = '{1, 3};

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ox[i] = 80 * 256; m_oy[i] = 0; m_st[i] = 0;
      m_hold[i] = 0; m_dir[i] = 0; m_ang[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [7:0] k, input logic d);
    longint nx, ny;
    int nd;
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] == 0) begin
        if (d) begin
          m_st[i] = 1; m_dir[i] = 0; m_hold[i] = 0;
        end else if (k == 8'h07 || k == 8'h04) begin
          nd = (k == 8'h07) ? 1 : 2;
          m_hold[i] = (nd == m_dir[i]) ? m_hold[i] + 1 : 0;
          m_dir[i] = nd;
          if (m_hold[i] % fdiv[i] == 0) begin
            if (nd == 1) begin
              nx = m_ox[i] - (m_oy[i] >>> 5); ny = m_oy[i] + (nx >>> 5);
              m_ang[i] = (m_ang[i] + 1) % 201;
            end else begin
              ny = m_oy[i] - (m_ox[i] >>> 5); nx = m_ox[i] + (ny >>> 5);
              m_ang[i] = (m_ang[i] + 200) % 201;
            end
            m_ox[i] = nx; m_oy[i] = ny;
          end
        end else begin
          m_dir[i] = 0; m_hold[i] = 0;
        end
      end else if (m_st[i] == 1) begin
        if (k == 8'h2C) begin
          m_ox[i] = 80 * 256; m_oy[i] = 0; m_ang[i] = 0; m_st[i] = 2;
        end
      end else begin
        if (k == 8'h00) m_st[i] = 0;
      end
    end
  endtask

  function automatic int scr(input int c, input longint off, input bit plus);
    longint p = off >>> 8;
    return int'((plus ? (c + p) : (c - p)) & 1023);
  endfunction

  task automatic compare_all();
    check_val("a_red_x",  int'(a_rx), scr(320, m_ox[0], 1'b1));
    check_val("a_red_y",  int'(a_ry), scr(360, m_oy[0], 1'b1));
    check_val("a_blue_x", int'(a_bx), scr(320, m_ox[0], 1'b0));
    check_val("a_blue_y", int'(a_by), scr(360, m_oy[0], 1'b0));
    check_val("a_alive",  int'(a_alive), (m_st[0] == 0) ? 1 : 0);
    check_val("a_balls",  int'(a_bs), 4);
    check_val("b_red_x",  int'(b_rx), scr(320, m_ox[1], 1'b1));
    check_val("b_red_y",  int'(b_ry), scr(360, m_oy[1], 1'b1));
    check_val("b_blue_x", int'(b_bx), scr(320, m_ox[1], 1'b0));
    check_val("b_blue_y", int'(b_by), scr(360, m_oy[1], 1'b0));
    check_val("b_alive",  int'(b_alive), (m_st[1] == 0) ? 1 : 0);
`ifdef ORBIT_ANGLE_OUT_EN
    check_val("a_angle", int'(a_ang), m_ang[0]);
    check_val("b_angle", int'(b_ang), m_ang[1]);
`endif
  endtask

  task automatic frame(input logic [7:0] k, input logic d);
    key = k; dead = d;
    @(posedge clk);
    model_edge(k, d);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] rk;
  logic       rd;

  initial begin
    key = 8'd0; dead = 1'b0; rst = 1'b1;
    #3;
    model_reset();
    compare_all();
    check_val("t1_red_x", int'(a_rx), 400);
    check_val("t1_blue_x", int'(a_bx), 240);
    check_val("t1_red_y", int'(a_ry), 360);
    check_val("t1_alive", int'(a_alive), 1);
    rst = 1'b0;

    frame(8'h07, 1'b0);
    check_val("t2_red_y", int'(a_ry), 362);
    check_val("t2_blue_y", int'(a_by), 358);
    check_val("t2_red_x", int'(a_rx), 400);
    frame(8'h04, 1'b0);
    check_val("t3_red_y", int'(a_ry), 360);
    check_val("t3_b_red_y", int'(b_ry), 360);
`ifdef ORBIT_ANGLE_OUT_EN
    check_val("t3_angle", int'(a_ang), 0);
`endif

    do_reset();
    for (int f = 1; f <= 7; f++) begin
      frame(8'h07, 1'b0);
      if (f == 1) check_val("t4_f1_red_y", int'(b_ry), 362);
      if (f == 3) check_val("t4_f3_red_y", int'(b_ry), 362);
      if (f == 4) check_val("t4_f4_red_y", int'(b_ry), 364);
      if (f == 7) check_val("t4_f7_red_y", int'(b_ry), 367);
    end
`ifdef ORBIT_ANGLE_OUT_EN
    check_val("t4_angle", int'(b_ang), 3);
`endif

    do_reset();
    frame(8'h07, 1'b0);
    frame(8'h07, 1'b0);
    frame(8'h07, 1'b1);
    check_val("t5_dead_alive", int'(a_alive), 0);
    check_val("t5_dead_red_y", int'(a_ry), 364);
    frame(8'h07, 1'b0);
    check_val("t5_frozen_red_y", int'(a_ry), 364);
    frame(8'h2C, 1'b0);
    check_val("t5_respawn_red_y", int'(a_ry), 360);
    check_val("t5_respawn_alive", int'(a_alive), 0);
    frame(8'h2C, 1'b1);
    check_val("t5_wait_alive", int'(a_alive), 0);
    frame(8'h00, 1'b1);
    check_val("t5_run_alive", int'(a_alive), 1);

    do_reset();
    frame(8'h04, 1'b0);
    frame(8'h04, 1'b0);
    frame(8'h04, 1'b0);
    key = 8'h04;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_val("t6_red_x", int'(a_rx), 400);
    check_val("t6_red_y", int'(a_ry), 360);
    check_val("t6_blue_y", int'(b_by), 360);
    compare_all();
    rst = 1'b0;

    rk = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: rk = 8'h07;
          4, 5:       rk = 8'h04;
          6, 9:       rk = 8'h00;
          7:          rk = 8'h2C;
          default:    rk = 8'($urandom_range(0, 255));
        endcase
      end
      rd = ($urandom_range(0, 24) == 0);
      frame(rk, rd);
      if ($urandom_range(0, 399) == 0) begin
        #2;
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
